cdb_arbiter: RTL and testbench

Shares the two common-data-bus broadcast channels (cdbIscast/cdbData/cdbRobNum and the matching *2 set) between completing functional units, such as the load unit and ALU/branch units, that write results back. Each requester gets a one-entry holding register. Round-robin arbitration grants up to two holders per cycle. Channel outputs are registered and drive every reservation station and the ROB directly.

---
 rtl/cdb_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the two common-data-bus broadcast channels between
// completing functional units. Each requester owns a one-entry holding slot.
// A round-robin scan grants up to two occupied slots per cycle, and the
// channel outputs are registered so they can drive every reservation station
// and the ROB directly.
//
// Optional build macro: CDB_ARB_RTZ_EN (return-to-zero). When it is defined,
// a channel that fired in one cycle sits out the next, so every strobe pulse
// is followed by at least one low cycle.
module cdb_arbiter #(
    parameter int                NUM_REQ  = 4,
    parameter int                DATA_W   = 32,
    parameter int                ROB_W    = 6,
    parameter logic [ROB_W-1:0]  IDLE_ROB = 6'b010000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ROB_W-1:0]    req_robNum,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        cdbIscast,
    output logic [DATA_W-1:0]           cdbData,
    output logic [ROB_W-1:0]            cdbRobNum,
    output logic                        cdbIscast2,
    output logic [DATA_W-1:0]           cdbData2,
    output logic [ROB_W-1:0]            cdbRobNum2,
    output logic [3:0]                  pending_count
);

    localparam int              PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]  NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

    // Holding slots: valid bits are control state, payloads are plain data.
    logic [NUM_REQ-1:0]  hold_v_q;
    logic [NUM_REQ-1:0]  hold_v_d;
    logic [ROB_W-1:0]    hold_tag_q  [NUM_REQ];
    logic [ROB_W-1:0]    hold_tag_d  [NUM_REQ];
    logic [DATA_W-1:0]   hold_data_q [NUM_REQ];
    logic [DATA_W-1:0]   hold_data_d [NUM_REQ];

    // Round-robin start point and registered channel outputs.
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    rr_ptr_d;
    logic                cdb_iscast_q;
    logic                cdb_iscast_d;
    logic [DATA_W-1:0]   cdb_data_q;
    logic [DATA_W-1:0]   cdb_data_d;
    logic [ROB_W-1:0]    cdb_rob_q;
    logic [ROB_W-1:0]    cdb_rob_d;
    logic                cdb_iscast2_q;
    logic                cdb_iscast2_d;
    logic [DATA_W-1:0]   cdb_data2_q;
    logic [DATA_W-1:0]   cdb_data2_d;
    logic [ROB_W-1:0]    cdb_rob2_q;
    logic [ROB_W-1:0]    cdb_rob2_d;
    logic [3:0]          pending_count_q;
    logic [3:0]          pending_count_d;

    // Arbitration results.
    logic                ch1_elig;
    logic                ch2_elig;
    logic                g1_v;
    logic [PTR_W-1:0]    g1_idx;
    logic                g2_v;
    logic [PTR_W-1:0]    g2_idx;
    logic                first_seen;
    logic                second_seen;
    logic [PTR_W:0]      scan_sum;
    logic [PTR_W-1:0]    scan_idx;
    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    last_idx;
    logic [PTR_W:0]      rr_next;
    logic                fire1;
    logic                fire2;

    // Channel eligibility: with return-to-zero a channel rests after firing.
`ifdef CDB_ARB_RTZ_EN
    always_comb begin
        ch1_elig = !cdb_iscast_q;
        ch2_elig = !cdb_iscast2_q;
    end
`else
    always_comb begin
        ch1_elig = 1'b1;
        ch2_elig = 1'b1;
    end
`endif

    // Round-robin scan from rr_ptr: first occupied slot to channel 1 (or to
    // channel 2 when only it is free), second occupied slot to channel 2.
    always_comb begin
        g1_v        = 1'b0;
        g1_idx      = '0;
        g2_v        = 1'b0;
        g2_idx      = '0;
        first_seen  = 1'b0;
        second_seen = 1'b0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= NUM_REQ_W) begin
                scan_sum = scan_sum - NUM_REQ_W;
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (hold_v_q[scan_idx]) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    if (ch1_elig) begin
                        g1_v   = 1'b1;
                        g1_idx = scan_idx;
                    end else if (ch2_elig) begin
                        g2_v   = 1'b1;
                        g2_idx = scan_idx;
                    end
                end else if (!second_seen) begin
                    second_seen = 1'b1;
                    if (ch1_elig && ch2_elig) begin
                        g2_v   = 1'b1;
                        g2_idx = scan_idx;
                    end
                end
            end
        end
    end

    // Per-slot grant mask and the ready handshake; a slot being drained this
    // cycle can take a new result on the same edge.
    always_comb begin
        grant     = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i]     = (g1_v && (g1_idx == PTR_W'(i))) ||
                           (g2_v && (g2_idx == PTR_W'(i)));
            req_ready[i] = !hold_v_q[i] || grant[i];
        end
    end

    // Pointer moves past the last slot granted; channel 2 is always later in
    // scan order than channel 1. A flush broadcasts nothing, so it holds.
    always_comb begin
        last_idx = g2_v ? g2_idx : g1_idx;
        rr_next  = {1'b0, last_idx} + (PTR_W+1)'(1);
        if (rr_next >= NUM_REQ_W) begin
            rr_next = '0;
        end
        rr_ptr_d = rr_ptr_q;
        if ((g1_v || g2_v) && !flush) begin
            rr_ptr_d = rr_next[PTR_W-1:0];
        end
    end

    // Slot update: a new capture wins over the drain of the old value; a
    // flush empties every slot and drops results offered in that cycle.
    always_comb begin
        hold_v_d    = hold_v_q;
        hold_tag_d  = hold_tag_q;
        hold_data_d = hold_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (flush) begin
                hold_v_d[i] = 1'b0;
            end else if (req_valid[i] && req_ready[i]) begin
                hold_v_d[i]    = 1'b1;
                hold_tag_d[i]  = req_robNum[i*ROB_W +: ROB_W];
                hold_data_d[i] = req_data[i*DATA_W +: DATA_W];
            end else if (grant[i]) begin
                hold_v_d[i] = 1'b0;
            end
        end
    end

    // Next channel contents: granted slot's payload, or the idle pattern.
    always_comb begin
        fire1         = g1_v && !flush;
        fire2         = g2_v && !flush;
        cdb_iscast_d  = fire1;
        cdb_data_d    = '0;
        cdb_rob_d     = IDLE_ROB;
        cdb_iscast2_d = fire2;
        cdb_data2_d   = '0;
        cdb_rob2_d    = IDLE_ROB;
        if (fire1) begin
            cdb_data_d = hold_data_q[g1_idx];
            cdb_rob_d  = hold_tag_q[g1_idx];
        end
        if (fire2) begin
            cdb_data2_d = hold_data_q[g2_idx];
            cdb_rob2_d  = hold_tag_q[g2_idx];
        end
    end

    // Occupancy after the edge, so the registered count matches hold_v_q.
    always_comb begin
        pending_count_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pending_count_d = pending_count_d + {3'b000, hold_v_d[i]};
        end
    end

    // Control state and broadcast registers; reset takes priority over flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_v_q        <= '0;
            rr_ptr_q        <= '0;
            cdb_iscast_q    <= 1'b0;
            cdb_data_q      <= '0;
            cdb_rob_q       <= IDLE_ROB;
            cdb_iscast2_q   <= 1'b0;
            cdb_data2_q     <= '0;
            cdb_rob2_q      <= IDLE_ROB;
            pending_count_q <= '0;
        end else begin
            hold_v_q        <= hold_v_d;
            rr_ptr_q        <= rr_ptr_d;
            cdb_iscast_q    <= cdb_iscast_d;
            cdb_data_q      <= cdb_data_d;
            cdb_rob_q       <= cdb_rob_d;
            cdb_iscast2_q   <= cdb_iscast2_d;
            cdb_data2_q     <= cdb_data2_d;
            cdb_rob2_q      <= cdb_rob2_d;
            pending_count_q <= pending_count_d;
        end
    end

    // Slot payloads are only meaningful while their valid bit is set.
    always_ff @(posedge clock) begin
        hold_tag_q  <= hold_tag_d;
        hold_data_q <= hold_data_d;
    end

    assign cdbIscast     = cdb_iscast_q;
    assign cdbData       = cdb_data_q;
    assign cdbRobNum     = cdb_rob_q;
    assign cdbIscast2    = cdb_iscast2_q;
    assign cdbData2      = cdb_data2_q;
    assign cdbRobNum2    = cdb_rob2_q;
    assign pending_count = pending_count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter with NUM_REQ=4, DATA_W=32,
// ROB_W=6. Inputs change on the falling edge; outputs are sampled there too.
module tb_cdb_arbiter;

    localparam logic [5:0]  IDLE = 6'd16;
    localparam logic [31:0] Z32  = 32'h0;

    logic         clock;
    logic         reset;
    logic         flush;
    logic [3:0]   req_valid;
    logic [23:0]  req_robNum;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         cdbIscast;
    logic [31:0]  cdbData;
    logic [5:0]   cdbRobNum;
    logic         cdbIscast2;
    logic [31:0]  cdbData2;
    logic [5:0]   cdbRobNum2;
    logic [3:0]   pending_count;

    int testsRun;
    int failCount;

    cdb_arbiter #(
        .NUM_REQ  (4),
        .DATA_W   (32),
        .ROB_W    (6),
        .IDLE_ROB (6'b010000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_robNum    (req_robNum),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .cdbIscast     (cdbIscast),
        .cdbData       (cdbData),
        .cdbRobNum     (cdbRobNum),
        .cdbIscast2    (cdbIscast2),
        .cdbData2      (cdbData2),
        .cdbRobNum2    (cdbRobNum2),
        .pending_count (pending_count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic setSlot(input int i, input logic [5:0] tag, input logic [31:0] data);
        req_robNum[i*6 +: 6]   = tag;
        req_data[i*32 +: 32]   = data;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic fl);
        req_valid = valid;
        flush     = fl;
    endtask

    task automatic checkField(input string name, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic checkOutput(input string name,
                               input logic v1, input logic [5:0] t1, input logic [31:0] d1,
                               input logic v2, input logic [5:0] t2, input logic [31:0] d2,
                               input logic [3:0] rdy, input logic [3:0] pend);
        checkField({name, ".cdbIscast"},     {63'b0, cdbIscast},     {63'b0, v1});
        checkField({name, ".cdbRobNum"},     {58'b0, cdbRobNum},     {58'b0, t1});
        checkField({name, ".cdbData"},       {32'b0, cdbData},       {32'b0, d1});
        checkField({name, ".cdbIscast2"},    {63'b0, cdbIscast2},    {63'b0, v2});
        checkField({name, ".cdbRobNum2"},    {58'b0, cdbRobNum2},    {58'b0, t2});
        checkField({name, ".cdbData2"},      {32'b0, cdbData2},      {32'b0, d2});
        checkField({name, ".req_ready"},     {60'b0, req_ready},     {60'b0, rdy});
        checkField({name, ".pending_count"}, {60'b0, pending_count}, {60'b0, pend});
    endtask

    task automatic checkIdle(input string name, input logic [3:0] rdy, input logic [3:0] pend);
        checkOutput(name, 1'b0, IDLE, Z32, 1'b0, IDLE, Z32, rdy, pend);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        step();
        step();
        reset = 1'b0;
    endtask

    // Directed sequence with hand-computed expectations.
    initial begin
        testsRun   = 0;
        failCount  = 0;
        reset      = 1'b1;
        flush      = 1'b0;
        req_valid  = '0;
        req_robNum = '0;
        req_data   = '0;
        @(negedge clock);
        doReset();

        // Reset state held over five idle cycles.
        for (int c = 0; c < 5; c++) begin
            step();
            checkIdle("reset_idle", 4'b1111, 4'd0);
        end

        // Single offer from requester 2: broadcast one cycle after capture.
        setSlot(2, 6'd5, 32'h1234);
        applyStimulus(4'b0100, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b0);
        checkIdle("single_captured", 4'b1111, 4'd1);
        step();
        checkOutput("single_bcast", 1'b1, 6'd5, 32'h1234, 1'b0, IDLE, Z32, 4'b1111, 4'd0);
        step();
        checkIdle("single_pulse_end", 4'b1111, 4'd0);

        // rr_ptr is now 3: slot 3 scans ahead of slot 0.
        setSlot(0, 6'd9,  32'hAAAA);
        setSlot(3, 6'd12, 32'hBBBB);
        applyStimulus(4'b1001, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b0);
        checkIdle("rr3_captured", 4'b1111, 4'd2);
        step();
        checkOutput("rr3_bcast", 1'b1, 6'd12, 32'hBBBB, 1'b1, 6'd9, 32'hAAAA, 4'b1111, 4'd0);

        doReset();
        checkIdle("reset2", 4'b1111, 4'd0);

        // All four requesters offer at once; tags 1..4.
        for (int i = 0; i < 4; i++) begin
            setSlot(i, 6'(i + 1), 32'hA0 + 32'(i));
        end
        applyStimulus(4'b1111, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b0);
        checkIdle("all4_captured", 4'b0011, 4'd4);
        step();
`ifdef CDB_ARB_RTZ_EN
        checkOutput("all4_c1", 1'b1, 6'd1, 32'hA0, 1'b1, 6'd2, 32'hA1, 4'b0011, 4'd2);
        step();
        checkIdle("all4_rest", 4'b1111, 4'd2);
        step();
        checkOutput("all4_c2", 1'b1, 6'd3, 32'hA2, 1'b1, 6'd4, 32'hA3, 4'b1111, 4'd0);
`else
        checkOutput("all4_c1", 1'b1, 6'd1, 32'hA0, 1'b1, 6'd2, 32'hA1, 4'b1111, 4'd2);
        step();
        checkOutput("all4_c2", 1'b1, 6'd3, 32'hA2, 1'b1, 6'd4, 32'hA3, 4'b1111, 4'd0);
`endif
        step();
        checkIdle("all4_done", 4'b1111, 4'd0);

        // rr_ptr back at 0: slot 1 must precede slot 3.
        setSlot(1, 6'd41, 32'h41);
        setSlot(3, 6'd43, 32'h43);
        applyStimulus(4'b1010, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b0);
        checkIdle("rr0_captured", 4'b1111, 4'd2);
        step();
        checkOutput("rr0_bcast", 1'b1, 6'd41, 32'h41, 1'b1, 6'd43, 32'h43, 4'b1111, 4'd0);

`ifndef CDB_ARB_RTZ_EN
        // Requester 0 streams every cycle while requester 1 offers once.
        doReset();
        setSlot(0, 6'd10, 32'h100);
        setSlot(1, 6'd20, 32'h200);
        applyStimulus(4'b0011, 1'b0);
        checkIdle("stream_offer", 4'b1111, 4'd0);
        step();
        checkIdle("stream_cap", 4'b1111, 4'd2);
        setSlot(0, 6'd11, 32'h101);
        applyStimulus(4'b0001, 1'b0);
        step();
        checkOutput("stream_b0", 1'b1, 6'd10, 32'h100, 1'b1, 6'd20, 32'h200, 4'b1111, 4'd1);
        setSlot(0, 6'd12, 32'h102);
        step();
        checkOutput("stream_b1", 1'b1, 6'd11, 32'h101, 1'b0, IDLE, Z32, 4'b1111, 4'd1);
        setSlot(0, 6'd13, 32'h103);
        step();
        checkOutput("stream_b2", 1'b1, 6'd12, 32'h102, 1'b0, IDLE, Z32, 4'b1111, 4'd1);
        applyStimulus(4'b0000, 1'b0);
        step();
        checkOutput("stream_b3", 1'b1, 6'd13, 32'h103, 1'b0, IDLE, Z32, 4'b1111, 4'd0);
        step();
        checkIdle("stream_done", 4'b1111, 4'd0);
`endif

        // Flush with three slots held; an offer during flush is dropped.
        doReset();
        setSlot(0, 6'd7, 32'h70);
        setSlot(1, 6'd8, 32'h80);
        setSlot(2, 6'd9, 32'h90);
        applyStimulus(4'b0111, 1'b0);
        step();
        checkIdle("flush_held", 4'b1011, 4'd3);
        setSlot(3, 6'd33, 32'h333);
        applyStimulus(4'b1000, 1'b1);
        step();
        applyStimulus(4'b0000, 1'b0);
        checkIdle("flush_edge", 4'b1111, 4'd0);
        step();
        checkIdle("flush_after", 4'b1111, 4'd0);

        // Reset asserted while a grant is pending.
        setSlot(0, 6'd5, 32'h55);
        setSlot(1, 6'd6, 32'h66);
        applyStimulus(4'b0011, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b0);
        checkIdle("rst_grant_held", 4'b1111, 4'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkIdle("rst_grant_edge", 4'b1111, 4'd0);
        step();
        checkIdle("rst_grant_after", 4'b1111, 4'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
